// File: rtl/vga_pkg.sv
// vga_pkg: screen codes shared with the screen selector, PS/2 constants and game-flow defaults
package vga_pkg;
  typedef enum logic [1:0] {
    START    = 2'd0,
    GAME     = 2'd1,
    PLAYER_1 = 2'd2,
    PLAYER_2 = 2'd3
  } screen_e;
  localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;
  localparam logic [7:0] PAUSE_KEY = 8'h4D;
  localparam logic [1:0] GUARD_INIT = 2'd3;
endpackage

// File: rtl/screen_fsm_if.sv
// screen_fsm_if: keyboard/score inputs and screen/game control outputs of the game-flow controller
interface screen_fsm_if;
  import vga_pkg::*;
  logic [15:0] keycode;
  logic [4:0]  p1_score;
  logic [4:0]  p2_score;
  screen_e     screen;
  logic        game_rst;
  logic        game_pause;
  modport master (output keycode, p1_score, p2_score, input screen, game_rst, game_pause);
  modport slave  (input keycode, p1_score, p2_score, output screen, game_rst, game_pause);
endinterface

// File: rtl/screen_fsm_key_event_detect.sv
// key_event_detect: one-cycle make-code event for CODE; held keys, repeats and break codes are ignored
module key_event_detect
  import vga_pkg::*;
#(
  parameter logic [7:0] CODE = 8'h5A
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] keycode_i,
  output logic        key_hit_o
);
  logic [15:0] key_prev_q;
  // remember last cycle's code so only a change counts as a new press
  always_ff @(posedge clk or posedge rst)
    if (rst) key_prev_q <= '0;
    else key_prev_q <= keycode_i;
  assign key_hit_o = (keycode_i != key_prev_q) && (keycode_i[15:8] != PS2_BREAK_PREFIX) && (keycode_i[7:0] == CODE);
endmodule

// File: rtl/screen_fsm.sv
// screen_fsm: START -> GAME -> PLAYER_1/PLAYER_2 -> START flow controller; SCREEN_FSM_PAUSE_EN adds 'P' pause in GAME
module screen_fsm
  import vga_pkg::*;
#(
  parameter int         WIN_SCORE       = 10,
  parameter int         WIN_HOLD_CYCLES = 195_000_000,
  parameter logic [7:0] START_KEY       = 8'h5A,
  parameter logic [7:0] QUIT_KEY        = 8'h76
) (
  input logic         clk,
  input logic         rst,
  screen_fsm_if.slave bus
);
  localparam int HW = (WIN_HOLD_CYCLES > 1) ? $clog2(WIN_HOLD_CYCLES) : 1;
  screen_e state_q, state_d;
  logic game_rst_q, game_rst_d;
  logic pause_q, pause_d;
  logic [1:0] guard_q, guard_d;
  logic [HW-1:0] hold_q, hold_d;
  logic start_hit, quit_hit, win_en, hold_done, p1_win, p2_win;

  key_event_detect #(.CODE(START_KEY)) u_start (.clk(clk), .rst(rst), .keycode_i(bus.keycode), .key_hit_o(start_hit));
  key_event_detect #(.CODE(QUIT_KEY))  u_quit  (.clk(clk), .rst(rst), .keycode_i(bus.keycode), .key_hit_o(quit_hit));

`ifdef SCREEN_FSM_PAUSE_EN
  logic pause_hit;
  key_event_detect #(.CODE(PAUSE_KEY)) u_pause (.clk(clk), .rst(rst), .keycode_i(bus.keycode), .key_hit_o(pause_hit));
`endif

  // wins are ignored until game_rst has flushed stale scores, and while paused
  assign win_en    = (guard_q == 2'd0) && !pause_q;
  assign p1_win    = win_en && (bus.p1_score >= 5'(WIN_SCORE));
  assign p2_win    = win_en && (bus.p2_score >= 5'(WIN_SCORE));
  assign hold_done = hold_q == HW'(WIN_HOLD_CYCLES - 1);

  // state and registered outputs
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q    <= START;
      game_rst_q <= 1'b0;
      pause_q    <= 1'b0;
      guard_q    <= 2'd0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      game_rst_q <= game_rst_d;
      pause_q    <= pause_d;
      guard_q    <= guard_d;
      hold_q     <= hold_d;
    end

  // next screen; quit beats a win, and player 1 takes a tie
  always_comb begin
    state_d = START;
    case (state_q)
      START:              state_d = start_hit ? GAME : START;
      GAME:               state_d = quit_hit ? START : p1_win ? PLAYER_1 : p2_win ? PLAYER_2 : GAME;
      PLAYER_1, PLAYER_2: state_d = (start_hit || hold_done) ? START : state_q;
      default:            state_d = START;
    endcase
  end

  // game reset pulse, guard window, win-screen hold timer and pause toggle
  always_comb begin
    game_rst_d = (state_q == START) && (state_d == GAME);
    guard_d    = (state_d != GAME) ? 2'd0 : (state_q != GAME) ? GUARD_INIT : (guard_q == 2'd0) ? 2'd0 : guard_q - 2'd1;
    hold_d     = ((state_q == PLAYER_1 || state_q == PLAYER_2) && state_d == state_q) ? hold_q + HW'(1) : '0;
`ifdef SCREEN_FSM_PAUSE_EN
    pause_d    = (state_q == GAME && state_d == GAME) ? (pause_q ^ pause_hit) : 1'b0;
`else
    pause_d    = 1'b0;
`endif
  end

  assign bus.screen     = state_q;
  assign bus.game_rst   = game_rst_q;
  assign bus.game_pause = pause_q;
endmodule

// File: tb/tb_screen_fsm.sv
// tb_screen_fsm: directed and randomized checks of screen_fsm against a cycle-age reference model
module tb_screen_fsm;
  localparam int HOLD = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int passed = 0;
  int total = 0;
  int m_scr = 0;
  int m_age = 0;
  bit m_rst = 0;
  bit m_pause = 0;
  logic [15:0] m_prev = 16'h0;

  screen_fsm_if bus();
  screen_fsm #(.WIN_SCORE(10), .WIN_HOLD_CYCLES(HOLD), .START_KEY(8'h5A), .QUIT_KEY(8'h76))
    dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  function automatic bit ev(input logic [7:0] k);
    return (bus.keycode != m_prev) && (bus.keycode[15:8] != 8'hF0) && (bus.keycode[7:0] == k);
  endfunction

  // model: screen, cycles spent on current screen, and last key; advances one clock
  task automatic cyc;
    int n;
    bit p;
    n = m_scr;
    p = 0;
    if (m_scr == 0) begin
      if (ev(8'h5A)) n = 1;
    end else if (m_scr == 1) begin
      if (ev(8'h76)) n = 0;
      else if (m_age >= 3 && !m_pause && bus.p1_score >= 10) n = 2;
      else if (m_age >= 3 && !m_pause && bus.p2_score >= 10) n = 3;
    end else if (ev(8'h5A) || m_age == HOLD - 1) n = 0;
`ifdef SCREEN_FSM_PAUSE_EN
    p = (m_scr == 1 && n == 1) ? (m_pause ^ ev(8'h4D)) : 1'b0;
`endif
    m_rst = (m_scr == 0 && n == 1);
    m_age = (n == m_scr) ? m_age + 1 : 0;
    m_scr = n;
    m_pause = p;
    m_prev = bus.keycode;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    m_scr = 0; m_age = 0; m_rst = 0; m_pause = 0; m_prev = 16'h0;
  endtask

  task automatic test_reset;
    bus.keycode = 16'h0; bus.p1_score = 5'd0; bus.p2_score = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({bus.screen, bus.game_rst, bus.game_pause} !== 4'b0000) $display("FAIL reset_init: got %b want 0000", {bus.screen, bus.game_rst, bus.game_pause});
    else passed++;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_start;
    bus.keycode = 16'h005A;
    cyc();
    total++;
    if (bus.screen !== 2'd1 || bus.game_rst !== 1'b1) $display("FAIL start_enter: screen %0d rst %b want 1 1", bus.screen, bus.game_rst);
    else passed++;
    for (int i = 0; i < 100; i++) begin
      cyc();
      total++;
      if (bus.screen !== 2'd1 || bus.game_rst !== 1'b0) $display("FAIL start_hold%0d: screen %0d rst %b want 1 0", i, bus.screen, bus.game_rst);
      else passed++;
    end
    bus.keycode = 16'hF05A;
    cyc();
    bus.keycode = 16'h005A;
    cyc();
    total++;
    if (bus.screen !== 2'd1 || bus.game_rst !== 1'b0) $display("FAIL start_in_game: screen %0d rst %b want 1 0", bus.screen, bus.game_rst);
    else passed++;
  endtask

  task automatic test_win;
    bus.keycode = 16'h0;
    bus.p1_score = 5'd9;
    repeat (5) cyc();
    total++;
    if (bus.screen !== 2'd1) $display("FAIL win_below: screen %0d want 1", bus.screen);
    else passed++;
    bus.p1_score = 5'd10;
    cyc();
    total++;
    if (bus.screen !== 2'd2) $display("FAIL win_p1: screen %0d want 2", bus.screen);
    else passed++;
    bus.keycode = 16'h005A;
    cyc();
    total++;
    if (bus.screen !== 2'd0) $display("FAIL win_dismiss: screen %0d want 0", bus.screen);
    else passed++;
    bus.keycode = 16'h0; bus.p1_score = 5'd0;
    cyc();
    bus.keycode = 16'h005A;
    cyc();
    repeat (4) cyc();
    bus.p1_score = 5'd10; bus.p2_score = 5'd10;
    cyc();
    total++;
    if (bus.screen !== 2'd2) $display("FAIL win_tie: screen %0d want 2", bus.screen);
    else passed++;
    bus.keycode = 16'h0;
    cyc();
    bus.keycode = 16'h005A;
    cyc();
    bus.p1_score = 5'd0; bus.p2_score = 5'd0;
    cyc();
  endtask

  task automatic test_guard;
    bus.keycode = 16'h0; bus.p2_score = 5'd12;
    cyc();
    bus.keycode = 16'h005A;
    cyc();
    cyc();
    bus.p2_score = 5'd0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      total++;
      if (bus.screen !== 2'd1) $display("FAIL guard%0d: screen %0d want 1", i, bus.screen);
      else passed++;
    end
  endtask

  task automatic test_hold;
    int n;
    bus.keycode = 16'h0;
    bus.p2_score = 5'd10;
    n = 0;
    while (bus.screen !== 2'd3 && n < 20) begin cyc(); n++; end
    n = 0;
    while (bus.screen === 2'd3 && n < 40) begin cyc(); n++; end
    total++;
    if (n !== HOLD) $display("FAIL hold_timeout: left after %0d cycles want %0d", n, HOLD);
    else passed++;
    bus.keycode = 16'h005A;
    cyc();
    bus.keycode = 16'h0;
    n = 0;
    while (bus.screen !== 2'd3 && n < 20) begin cyc(); n++; end
    repeat (5) cyc();
    bus.keycode = 16'h005A;
    cyc();
    total++;
    if (bus.screen !== 2'd0 || m_scr != 0) $display("FAIL hold_key: screen %0d want 0", bus.screen);
    else passed++;
    bus.p2_score = 5'd0;
  endtask

  task automatic test_quit_and_reset;
    bus.keycode = 16'h0;
    cyc();
    bus.keycode = 16'h005A;
    cyc();
    bus.keycode = 16'h0076;
    cyc();
    total++;
    if (bus.screen !== 2'd0) $display("FAIL quit: screen %0d want 0", bus.screen);
    else passed++;
    bus.keycode = 16'h005A;
    cyc();
    repeat (3) cyc();
    #3 rst = 1'b1;
    #1;
    total++;
    if ({bus.screen, bus.game_rst, bus.game_pause} !== 4'b0000) $display("FAIL reset_async: got %b want 0000", {bus.screen, bus.game_rst, bus.game_pause});
    else passed++;
    bus.keycode = 16'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

`ifdef SCREEN_FSM_PAUSE_EN
  task automatic test_pause;
    bus.keycode = 16'h005A;
    cyc();
    bus.keycode = 16'h004D;
    repeat (4) cyc();
    total++;
    if (bus.game_pause !== 1'b1) $display("FAIL pause_on: pause %b want 1", bus.game_pause);
    else passed++;
    bus.p1_score = 5'd10;
    repeat (3) cyc();
    total++;
    if (bus.screen !== 2'd1) $display("FAIL pause_nowin: screen %0d want 1", bus.screen);
    else passed++;
    bus.keycode = 16'h0076;
    cyc();
    total++;
    if (bus.screen !== 2'd0 || bus.game_pause !== 1'b0) $display("FAIL pause_quit: screen %0d pause %b want 0 0", bus.screen, bus.game_pause);
    else passed++;
    bus.p1_score = 5'd0;
  endtask
`endif

  task automatic test_random;
    logic [15:0] codes [7];
    codes = '{16'h0000, 16'h005A, 16'hF05A, 16'h0076, 16'hF076, 16'h004D, 16'h0012};
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) bus.keycode = codes[$urandom_range(6)];
      if ($urandom_range(7) == 0) bus.p1_score = 5'($urandom_range(12));
      if ($urandom_range(7) == 0) bus.p2_score = 5'($urandom_range(12));
      cyc();
      total++;
      if (bus.screen !== 2'(m_scr) || bus.game_rst !== m_rst || bus.game_pause !== m_pause)
        $display("FAIL rand%0d: screen %0d rst %b pause %b want %0d %b %b", i, bus.screen, bus.game_rst, bus.game_pause, m_scr, m_rst, m_pause);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_win();
    test_guard();
    test_hold();
    test_quit_and_reset();
`ifdef SCREEN_FSM_PAUSE_EN
    test_pause();
`endif
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/screen_fsm.md
Name: screen_fsm

Overview:
- Game-flow controller that produces the 2-bit screen code consumed by the VGA screen multiplexer.
- Decodes keyboard keycodes, watches both players' scores and sequences START -> GAME -> PLAYER_1/PLAYER_2 -> START.
- Issues a one-cycle game reset pulse to the game-drawing logic on every new game.
- Sits between the keyboard decoder / game logic and the screen selector, in the pixel clock domain.

Parameters:
- WIN_SCORE, 10, score at or above which a player wins (range 1..31).
- WIN_HOLD_CYCLES, 195_000_000, clock cycles a win screen is held before auto-return to START (3 s at 65 MHz).
- START_KEY, 8'h5A, make code that starts a game and dismisses a win screen (Enter).
- QUIT_KEY, 8'h76, make code that aborts a game back to START (Esc).

Ports:
- clk  input  1  pixel clock
- rst  input  1  asynchronous reset, active-high
- keycode  input  16  latest PS/2 code; [15:8]=8'hF0 marks a break code
- p1_score  input  5  player 1 total score
- p2_score  input  5  player 2 total score
- screen  output  2  screen code: START, GAME, PLAYER_1, PLAYER_2
- game_rst  output  1  one-cycle pulse, resets game state and scores
- game_pause  output  1  game frozen (constant 0 unless SCREEN_FSM_PAUSE_EN)

Behaviour:
- Single clk domain. All flops use asynchronous active-high rst. All outputs are registered.
- Reset values: screen=START, game_rst=0, game_pause=0, internal key_prev=16'h0000, hold counter=0, guard counter=0.
- Key event:
  - key_hit asserts for one cycle when keycode != key_prev, keycode[15:8] != 8'hF0, and keycode[7:0] == the key of interest.
  - key_prev updates every cycle.
  - A held key or a repeated identical code produces no new event.
  - A break code never triggers an event.
- State = screen register. Transitions take effect on the clk edge after the triggering input is sampled (latency 1 cycle).
- START:
  - START_KEY event -> GAME, game_rst=1 for exactly that first GAME cycle.
  - Every other input is ignored.
- GAME, on entry:
  - guard counter loads 3. Win check is disabled while guard != 0, so stale scores are flushed by game_rst.
  - guard decrements once per cycle.
- GAME, priority in the same cycle:
  1. QUIT_KEY event -> START.
  2. Else if guard==0 and p1_score >= WIN_SCORE -> PLAYER_1. Player 1 also wins a tie where both players reach WIN_SCORE.
  3. Else if guard==0 and p2_score >= WIN_SCORE -> PLAYER_2.
- Score compare is unsigned 5-bit.
- PLAYER_1 / PLAYER_2:
  - Hold counter counts up from 0 from the first cycle in the state.
  - START_KEY event, or counter reaching WIN_HOLD_CYCLES-1 -> START. The counter clears on exit.
  - The key event wins if both occur in the same cycle; the result is identical.
  - Counter width is $clog2(WIN_HOLD_CYCLES). It never wraps.
- Unreachable encodings never occur. The default branch forces START.
- game_rst never asserts outside the START->GAME transition.

Optional Feature:
- SCREEN_FSM_PAUSE_EN defined:
  - In GAME, a make event for 8'h4D ('P') toggles game_pause.
  - Win check is suspended while game_pause=1.
  - QUIT_KEY still exits and clears game_pause.
  - game_pause clears on any exit from GAME and on rst.
- Not defined: game_pause is tied to 0 and the 'P' key is ignored.

Decomposition:
- vga_pkg holds the screen codes: START=2'd0, GAME=2'd1, PLAYER_1=2'd2, PLAYER_2=2'd3. The screen selector shares these constants.
- vga_pkg also holds PS2_BREAK_PREFIX=8'hF0.
- One sub-module, key_event_detect: per-instance 8-bit code parameter, registered key_prev, one-cycle key_hit output.
  - Instantiated for START_KEY, QUIT_KEY and, under the macro, the pause key.

Test Plan:
- Reset mid-GAME (assert rst asynchronously between edges) -> screen=START, game_rst=0, game_pause=0 immediately, before the next clk edge.
- keycode 16'h005A in START -> next edge screen=GAME, game_rst high exactly 1 cycle. Holding 16'h005A for 100 cycles gives no further pulse. Then 16'hF05A followed by 16'h005A in GAME gives no transition.
- GAME with p1_score=9, raise to 10 (WIN_SCORE=10) -> screen=PLAYER_1 one cycle later. p1_score=p2_score=10 same cycle -> PLAYER_1.
- Enter GAME with stale p2_score=12 that drops to 0 after game_rst -> screen stays GAME (guard window).
- WIN_HOLD_CYCLES=16 in PLAYER_2 with no key -> START exactly 16 cycles after entry. Second run with 16'h005A at cycle 5 -> START at cycle 6.
- With SCREEN_FSM_PAUSE_EN: 16'h004D in GAME -> game_pause=1. Then p1_score=10 -> stays GAME. Then 16'h0076 -> START, game_pause=0.
